multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multi-cycle MIPS datapath variant. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU, memory and register-file enables cycle by cycle. A single unified memory port with a ready handshake is stalled on. Supported instructions are R-type (add, sub, and, or, slt), lw, sw, beq, addi and j; any other encoding parks the block in a sticky fault state.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC load
- Branch  out  1  conditional PC load; datapath forms PCEn = PCWrite | (Branch & Zero)
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUControl  out  3  and 000, or 001, add 010, sub 110, slt 111
- RegDst  out  1  1 = rd, 0 = rt
- MemToReg  out  1  1 = memory data register, 0 = ALUOut
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write enable
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- fault  out  1  high while in the FAULT state
- state  out  4  current state encoding, for debug

## Operation
- **Encodings:**
  - States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, FAULT 12.
  - Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
  - Funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- **Default outputs:** every output not listed for a state is 0, and ALUControl defaults to 010.
- **FETCH:** mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- **DECODE:** ALUSrcA=0, ALUSrcB=11 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R-type with a supported funct → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - anything else, including R-type with an unsupported funct → FAULT
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, add. Go to MEMRD for lw, MEMWR for sw.
- **MEMRD:** mem_req=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- **MEMWB:** RegWrite=1, RegDst=0, MemToReg=1, instr_done=1. Go to FETCH.
- **MEMWR:** mem_req=1, IorD=1. MemWrite=1 for every cycle spent in this state. Wait for mem_ready; on that cycle instr_done=1, then go to FETCH.
- **EXEC:** ALUSrcA=1, ALUSrcB=00, ALUControl from funct. Go to ALUWB.
- **ALUWB:** RegWrite=1, RegDst=1, MemToReg=0, instr_done=1. Go to FETCH.
- **BRANCH:** ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01, instr_done=1. Go to FETCH.
- **ADDIEX:** ALUSrcA=1, ALUSrcB=10, add. Go to ADDIWB.
- **ADDIWB:** RegWrite=1, RegDst=0, MemToReg=0, instr_done=1. Go to FETCH.
- **JUMP:** PCWrite=1, PCSrc=10, instr_done=1. Go to FETCH.
- **FAULT:** fault=1, all enables 0. Stays in FAULT until rst.

## Timing
- **Registered state:** state is the only register. All outputs decode combinationally from state, opcode, funct and mem_ready.
- **Reset:**
  - With rst high at a rising edge, the next state is FETCH, from any state including FAULT and mid-wait in MEMRD/MEMWR.
  - While rst=1: mem_req, IRWrite, PCWrite, Branch, RegWrite, MemWrite, instr_done and fault are forced to 0. The mux selects keep their FETCH values.
- **Latency with mem_ready tied high:** R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3.
- **Memory stalls:** each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. mem_ready is ignored in all other states.
- **Input stability:** opcode and funct are sampled only from DECODE onward, after the IR load. Their values during FETCH are don't-care.
- **instr_done:** exactly one pulse per retired instruction; never asserted in FETCH or FAULT.

## Test plan
- **Reset:** hold rst 2 cycles with mem_ready=1 → state=0; PCWrite, IRWrite, mem_req and all other enables 0. On release, FETCH asserts mem_req=1, IorD=0, ALUSrcB=01.
- **add:** opcode 000000, funct 100000, mem_ready=1 → states 0,1,6,7. In ALUWB: RegWrite=1, RegDst=1, ALUControl=010 in EXEC. instr_done on cycle 4.
- **lw with memory stall:** opcode 100011, mem_ready low for 2 cycles in MEMRD → 0,1,2,3,3,3,4. MEMWB: MemToReg=1, RegWrite=1. Total 7 cycles.
- **sw:** opcode 101011, mem_ready=1 → MEMWR asserts MemWrite=1, IorD=1 and instr_done for 1 cycle. beq: 3 cycles, with Branch=1, PCSrc=01, ALUControl=110 in BRANCH.
- **j then illegal:**
  - j (000010) → JUMP with PCWrite=1, PCSrc=10.
  - Next opcode 111111 → FAULT (state=12, fault=1), which persists 10 cycles.
  - rst → returns to FETCH with fault=0.
- **Unsupported funct:** R-type with funct 000000 → DECODE goes to FAULT. RegWrite is never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller: steps fetch/decode/execute/memory/writeback
// and decodes datapath enables and mux selects from the current state.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur, nxt;
  logic       funct_ok;
  logic [2:0] funct_alu;

  assign state = cur;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = funct_ok ? S_EXEC : S_FAULT;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   nxt = S_MEMRD;
          OP_SW:   nxt = S_MEMWR;
          default: nxt = S_FAULT;
        endcase
      end
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWB:  nxt = S_FETCH;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC:   nxt = S_ALUWB;
      S_ALUWB:  nxt = S_FETCH;
      S_BRANCH: nxt = S_FETCH;
      S_ADDIEX: nxt = S_ADDIWB;
      S_ADDIWB: nxt = S_FETCH;
      S_JUMP:   nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_FAULT;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    fault      = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      // Branch target computed here so BRANCH can compare registers and load PC in one cycle.
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
    // Reset kills every enable immediately; selects fall back to FETCH values.
    if (rst) begin
      mem_req    = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b01;
      ALUControl = ALU_ADD;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      fault      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against an instruction-path model.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mem_req, iord, irwrite, pcwrite, branch;
    logic [1:0] pcsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic       regdst, memtoreg, regwrite, memwrite, done, fault;
  } outs_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       mem_req, IorD, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemToReg;
  logic       RegWrite, MemWrite, instr_done, fault;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .instr_done(instr_done), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic outs_t actual();
    return {mem_req, IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
            RegDst, MemToReg, RegWrite, MemWrite, instr_done, fault};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs of each named step of an instruction, straight from the datapath table.
  function automatic outs_t exp_outs(input int st, input logic [5:0] fn, input logic mr);
    outs_t o;
    o = '0;
    o.aluc = 3'b010;
    case (st)
      0:  begin o.mem_req = 1; o.srcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      1:  o.srcb = 2'b11;
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  begin o.mem_req = 1; o.iord = 1; end
      4:  begin o.regwrite = 1; o.memtoreg = 1; o.done = 1; end
      5:  begin o.mem_req = 1; o.iord = 1; o.memwrite = 1; o.done = mr; end
      6:  begin o.srca = 1; o.aluc = alu_of(fn); end
      7:  begin o.regwrite = 1; o.regdst = 1; o.done = 1; end
      8:  begin o.srca = 1; o.aluc = 3'b110; o.branch = 1; o.pcsrc = 2'b01; o.done = 1; end
      9:  begin o.srca = 1; o.srcb = 2'b10; end
      10: begin o.regwrite = 1; o.done = 1; end
      11: begin o.pcwrite = 1; o.pcsrc = 2'b10; o.done = 1; end
      12: o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t reset_outs();
    outs_t o;
    o = '0;
    o.srcb = 2'b01;
    o.aluc = 3'b010;
    return o;
  endfunction

  function automatic int lat_of(input logic [5:0] op);
    case (op)
      OP_LW:          return 5;
      OP_BEQ, OP_J:   return 3;
      default:        return 4;
    endcase
  endfunction

  // Walks one instruction through its state path; sf/sm are stall cycles in fetch/memory.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int sf,
                           input int sm, input int nfault, output int done_cnt,
                           output int done_at, output int rw_cnt);
    int stages[$];
    int s, reps, cyc;
    bit waits, legal_r;
    logic mr;
    outs_t a, e;
    legal_r = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
              (fn == 6'b100101) || (fn == 6'b101010);
    stages.push_back(0);
    stages.push_back(1);
    case (op)
      OP_LW:   begin stages.push_back(2); stages.push_back(3); stages.push_back(4); end
      OP_SW:   begin stages.push_back(2); stages.push_back(5); end
      OP_BEQ:  stages.push_back(8);
      OP_ADDI: begin stages.push_back(9); stages.push_back(10); end
      OP_J:    stages.push_back(11);
      OP_R:    if (legal_r) begin stages.push_back(6); stages.push_back(7); end
               else stages.push_back(12);
      default: stages.push_back(12);
    endcase
    done_cnt = 0; done_at = -1; rw_cnt = 0; cyc = 0;
    foreach (stages[i]) begin
      s = stages[i];
      waits = (s == 0) || (s == 3) || (s == 5);
      reps = (s == 12) ? nfault : (s == 0) ? sf + 1 : waits ? sm + 1 : 1;
      for (int k = 0; k < reps; k++) begin
        mr = waits ? (k == reps - 1) : 1'($urandom);
        mem_ready = mr;
        if (s == 0) begin
          opcode = 6'($urandom);
          funct  = 6'($urandom);
        end else begin
          opcode = op;
          funct  = fn;
        end
        @(negedge clk);
        a = actual();
        e = exp_outs(s, fn, mr);
        vectors++;
        if (state !== 4'(s)) begin
          miscompares++;
          $display("FAIL state op=%b fn=%b cyc=%0d got %0d want %0d", op, fn, cyc, state, s);
        end
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs op=%b st=%0d cyc=%0d got %h want %h", op, s, cyc, a, e);
        end
        if (instr_done === 1'b1) begin done_cnt++; done_at = cyc; end
        if (RegWrite === 1'b1) rw_cnt++;
        cyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    outs_t a;
    rst = 1; mem_ready = 1; opcode = '0; funct = '0;
    @(posedge clk); #1;
    @(negedge clk);
    a = actual();
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++;
    if (a !== reset_outs()) begin
      miscompares++; $display("FAIL reset_outs got %h want %h", a, reset_outs());
    end
    @(posedge clk); #1;
    rst = 0; mem_ready = 0;
    @(negedge clk);
    a = actual();
    vectors++;
    if (a !== exp_outs(0, 6'd0, 1'b0)) begin
      miscompares++; $display("FAIL fetch_after_reset got %h want %h", a, exp_outs(0, 6'd0, 1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int dc, da, rw;
    run_instr(OP_R, 6'b100000, 0, 0, 0, dc, da, rw);
    vectors++;
    if (dc !== 1 || da !== 3) begin
      miscompares++; $display("FAIL add_done got cnt=%0d at=%0d want cnt=1 at=3", dc, da);
    end
    vectors++;
    if (rw !== 1) begin miscompares++; $display("FAIL add_regwrite got %0d want 1", rw); end
  endtask

  task automatic test_lw_stall();
    int dc, da, rw;
    run_instr(OP_LW, 6'd0, 0, 2, 0, dc, da, rw);
    vectors++;
    if (dc !== 1 || da !== 6) begin
      miscompares++; $display("FAIL lw_stall_done got cnt=%0d at=%0d want cnt=1 at=6", dc, da);
    end
  endtask

  task automatic test_sw_beq();
    int dc, da, rw;
    run_instr(OP_SW, 6'd0, 0, 0, 0, dc, da, rw);
    vectors++;
    if (dc !== 1 || da !== 3 || rw !== 0) begin
      miscompares++; $display("FAIL sw_done got cnt=%0d at=%0d rw=%0d want 1 3 0", dc, da, rw);
    end
    run_instr(OP_BEQ, 6'd0, 1, 0, 0, dc, da, rw);
    vectors++;
    if (dc !== 1 || da !== 3) begin
      miscompares++; $display("FAIL beq_done got cnt=%0d at=%0d want cnt=1 at=3", dc, da);
    end
  endtask

  task automatic test_j_illegal();
    int dc, da, rw;
    run_instr(OP_J, 6'd0, 0, 0, 0, dc, da, rw);
    vectors++;
    if (dc !== 1 || da !== 2) begin
      miscompares++; $display("FAIL j_done got cnt=%0d at=%0d want cnt=1 at=2", dc, da);
    end
    run_instr(6'b111111, 6'd0, 0, 0, 10, dc, da, rw);
    vectors++;
    if (dc !== 0) begin miscompares++; $display("FAIL illegal_done got %0d want 0", dc); end
    rst = 1;
    @(negedge clk);
    vectors++;
    if (fault !== 1'b0 || state !== 4'd12) begin
      miscompares++; $display("FAIL fault_rst_force got fault=%b st=%0d want 0 12", fault, state);
    end
    @(posedge clk); #1;
    rst = 0; mem_ready = 0;
    @(negedge clk);
    vectors++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      miscompares++; $display("FAIL fault_recover got st=%0d fault=%b want 0 0", state, fault);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_funct();
    int dc, da, rw;
    run_instr(OP_R, 6'b000000, 0, 0, 4, dc, da, rw);
    vectors++;
    if (rw !== 0 || dc !== 0) begin
      miscompares++; $display("FAIL bad_funct got rw=%0d done=%0d want 0 0", rw, dc);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_ready = 0;
    @(negedge clk);
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL bad_funct_recover got %0d want 0", state); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midwait();
    mem_ready = 1; opcode = $urandom; funct = $urandom;
    @(posedge clk); #1;
    opcode = OP_SW; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd5 || MemWrite !== 1'b1 || instr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_wait got st=%0d mw=%b done=%b want 5 1 0", state, MemWrite, instr_done);
    end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    vectors++;
    if (state !== 4'd5 || MemWrite !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL midwait_rst got st=%0d mw=%b req=%b want 5 0 0", state, MemWrite, mem_req);
    end
    @(posedge clk); #1;
    rst = 0; mem_ready = 0;
    @(negedge clk);
    vectors++;
    if (state !== 4'd0 || mem_req !== 1'b1) begin
      miscompares++; $display("FAIL midwait_recover got st=%0d req=%b want 0 1", state, mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [10];
    int dc, da, rw, idx, sf, sm, want;
    ops = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 9);
      sf  = $urandom_range(0, 3);
      sm  = $urandom_range(0, 3);
      run_instr(ops[idx], fns[idx], sf, sm, 0, dc, da, rw);
      want = lat_of(ops[idx]) - 1 + sf + ((ops[idx] == OP_LW || ops[idx] == OP_SW) ? sm : 0);
      vectors++;
      if (dc !== 1 || da !== want) begin
        miscompares++;
        $display("FAIL rand_latency op=%b got cnt=%0d at=%0d want cnt=1 at=%0d", ops[idx], dc, da, want);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout after %0d vectors", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_sw_beq();
    test_j_illegal();
    test_bad_funct();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
